alu_sequencer: RTL and testbench
================================

# alu_sequencer

Controller that sequences the shared 8-bit ALU datapath (AND/OR/NOT/XOR/ADD/SUB/MUL with registered operand stage). It accepts one operation request at a time over a valid/ready handshake, drives the ALU operand, input-select and output-select controls, waits the fixed datapath latency, and returns the result with an error flag over a second valid/ready handshake. It sits between the requesting logic and the ALU, and owns the off/ready/run/error sequencing and the accumulator (chained operand) register.

## Interface
- WIDTH, 8, operand/result width
- LAT, 2, ALU latency in cycles from operand load to valid result (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- on  in  1  enable; 0 parks the block in OFF once idle
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_op  in  3  0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MUL, 7 illegal
- req_chain  in  1  1: operand A = last good result, req_a ignored
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- alu_in_sel  out  3  one-hot: 100 persist, 010 load, 001 reset
- alu_num1  out  WIDTH  ALU operand 1
- alu_num2  out  WIDTH  ALU operand 2
- alu_out_sel  out  7  one-hot result select, bit n = opcode n
- alu_result  in  WIDTH  ALU result
- alu_ovf  in  1  ALU multiply overflow
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  WIDTH  result
- rsp_err  out  1  1 = illegal opcode or MUL overflow
- state  out  3  current state encoding (debug)

## Operation
- States: OFF, READY, RUN, RESP, ERR.
- OFF: alu_in_sel=001; on=1 → READY.
- READY: req_ready=on. on=0 → OFF. Accept with op≤6 → RUN (cnt=0); accept with op=7 → RESP, rsp_data=0, rsp_err=1, ALU untouched.
- RUN: operands/op latched at accept; alu_num1=chain?last_q:req_a, alu_num2=req_b (0 for NOT); alu_out_sel=1<<op held throughout. cnt=0: alu_in_sel=010; else 100. At cnt=LAT-1 capture alu_result → rsp_data, err=(op==MUL)&alu_ovf → rsp_err; → RESP.
- RESP: rsp_valid=1, rsp_data/rsp_err stable until handshake. On handshake: err=0 → last_q=rsp_data, → READY; err=1 → ERR.
- ERR: one cycle, alu_in_sel=001, last_q=0, → READY.
- on deasserted in RUN/RESP/ERR: ignored until back in READY, then → OFF.
- Arithmetic is done by the ALU; block passes WIDTH-bit values only, no extension or truncation.

## Timing
- Reset (async, immediate): state=OFF, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, alu_in_sel=001, alu_num1=0, alu_num2=0, alu_out_sel=0, last_q=0.
- Accept at cycle T → RUN T+1..T+LAT → rsp_valid first high at T+LAT+1.
- Illegal op accepted at T → rsp_valid at T+1.
- Earliest next accept: cycle after response handshake (+1 more if ERR). Peak throughput one op per LAT+2 cycles.
- req_ready is 0 in every state except READY; never combinationally depends on req_valid.
- Reset asserted mid-RUN/RESP: operation dropped, no response, last_q cleared.

## Structure
- Shared package alu_pkg: opcode constants, state encodings, alu_in_sel constants (PERSIST/LOAD/RESET), opcode→one-hot out_sel function.
- One sub-module: alu_op_decode (combinational: opcode → alu_out_sel, illegal flag, uses_b flag).
- Bench ALU model: LAT-cycle pipeline, ovf when 16-bit product >255.

## Test plan
- Reset: rst_n=0 with any stimulus → state=OFF, all outputs at reset values, alu_in_sel=001; release with on=0 stays OFF.
- ADD 100+27, on=1, accept at T → alu_in_sel=010 at T+1, 100 at T+2, alu_out_sel=0010000; rsp_valid at T+3, rsp_data=127, rsp_err=0.
- Chain: after 127, MUL chain=1 b=2 → 254, err 0; repeat MUL chain b=2 → alu_ovf=1, rsp_err=1; next cycle ERR with alu_in_sel=001; subsequent chained ADD b=5 → 5.
- Illegal op 7, a=8'hFF → rsp_valid at T+1, rsp_data=0, rsp_err=1, alu_in_sel never 010.
- Backpressure: rsp_ready=0 for 5 cycles after XOR 8'hF0^8'h3C → rsp_valid held, rsp_data=8'hCC stable, req_ready=0; rsp_ready=1 → READY next cycle.
- rst_n pulse during RUN of SUB 9-4 → immediate OFF, rsp_valid never asserted, last_q=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, ALU input-select codes.
// Latency: none (package only).
// Backpressure: not applicable.
package alu_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_XOR     = 3'd3;
  localparam logic [2:0] OP_ADD     = 3'd4;
  localparam logic [2:0] OP_SUB     = 3'd5;
  localparam logic [2:0] OP_MUL     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } aluState_t;

  // ALU operand-stage control, one-hot
  localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
  localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [2:0] IN_SEL_RESET   = 3'b001;

  // Bit n set for opcode n; the illegal opcode shifts out of the 7-bit field and yields zero
  function automatic logic [6:0] opToOutSel(input logic [2:0] op);
    logic [7:0] oneHot;
    oneHot = 8'd1 << op;
    return oneHot[6:0];
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decode: one-hot ALU result select, illegal-opcode flag, operand-B usage flag.
// Latency: purely combinational.
// Backpressure: none, follows its input every cycle.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic [6:0] outSel,
  output logic       illegal,
  output logic       usesB
);

  // Decode the request opcode; NOT is the only unary operation
  always_comb begin
    outSel  = opToOutSel(op);
    illegal = (op == OP_ILLEGAL);
    usesB   = (op != OP_NOT);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the shared ALU: latches one request, drives operands/selects, returns result + error.
// Latency: accept at T -> response valid at T+LAT+1 (illegal opcode: T+1).
// Backpressure: one op in flight; req_ready low outside READY, response held until rsp_ready.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             on,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_chain,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [2:0]       alu_in_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [2:0]       state
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  aluState_t        curState;
  logic [CNT_W-1:0] cnt;
  logic             isMul;
  logic [WIDTH-1:0] lastQ;

  logic [6:0] decOutSel;
  logic       decIllegal;
  logic       decUsesB;

  alu_op_decode uDecode (
    .op      (req_op),
    .outSel  (decOutSel),
    .illegal (decIllegal),
    .usesB   (decUsesB)
  );

  // Ready depends only on state and enable, never on req_valid
  assign req_ready = (curState == ST_READY) && on;
  assign state     = curState;

  // Main sequencer: state, ALU controls, response and chained-operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState    <= ST_OFF;
      cnt         <= '0;
      isMul       <= 1'b0;
      lastQ       <= '0;
      alu_in_sel  <= IN_SEL_RESET;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      unique case (curState)
        ST_OFF: begin
          if (on) begin
            curState   <= ST_READY;
            alu_in_sel <= IN_SEL_PERSIST;
          end
        end

        ST_READY: begin
          if (!on) begin
            curState   <= ST_OFF;
            alu_in_sel <= IN_SEL_RESET;
          end else if (req_valid) begin
            if (decIllegal) begin
              // Illegal opcode answers directly and leaves the ALU untouched
              curState  <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
            end else begin
              curState    <= ST_RUN;
              cnt         <= '0;
              alu_in_sel  <= IN_SEL_LOAD;
              alu_num1    <= req_chain ? lastQ : req_a;
              alu_num2    <= decUsesB ? req_b : '0;
              alu_out_sel <= decOutSel;
              isMul       <= (req_op == OP_MUL);
            end
          end
        end

        ST_RUN: begin
          // Operands were loaded in the first RUN cycle; hold them until the result is due
          alu_in_sel <= IN_SEL_PERSIST;
          if (cnt == CNT_LAST) begin
            curState  <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
            rsp_err   <= isMul & alu_ovf;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_err) begin
              curState   <= ST_ERR;
              alu_in_sel <= IN_SEL_RESET;
            end else begin
              lastQ    <= rsp_data;
              curState <= ST_READY;
            end
          end
        end

        ST_ERR: begin
          // A failed result never feeds a chain: the accumulator restarts from zero
          lastQ      <= '0;
          alu_in_sel <= IN_SEL_PERSIST;
          curState   <= ST_READY;
        end

        default: begin
          curState <= ST_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int WIDTH = 8;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       on = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic       req_chain = 1'b0;
  logic [7:0] req_a = 8'd0;
  logic [7:0] req_b = 8'd0;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_result;
  logic       alu_ovf;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [2:0] state;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  alu_sequencer #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .on(on),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_chain(req_chain),
    .req_a(req_a), .req_b(req_b),
    .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
    .alu_result(alu_result), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
  endtask

  // Reference arithmetic: {flag, result}; flag = MUL overflow, or illegal opcode
  function automatic logic [8:0] refOp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~a};
      3'd3: return {1'b0, a ^ b};
      3'd4: return {1'b0, 8'(a + b)};
      3'd5: return {1'b0, 8'(a - b)};
      3'd6: return {p > 16'd255, p[7:0]};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  // Environment ALU: registered operand stage, result from the one-hot select
  logic [7:0] aluR1 = 8'd0, aluR2 = 8'd0;
  logic [2:0] aluIdx;
  logic [8:0] aluFull;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluR1 <= 8'd0; aluR2 <= 8'd0;
    end else if (alu_in_sel == 3'b010) begin
      aluR1 <= alu_num1; aluR2 <= alu_num2;
    end else if (alu_in_sel == 3'b001) begin
      aluR1 <= 8'd0; aluR2 <= 8'd0;
    end
  end
  always_comb begin
    aluIdx = 3'd7;
    for (int k = 0; k < 7; k++) if (alu_out_sel[k]) aluIdx = 3'(k);
    aluFull    = refOp(aluIdx, aluR1, aluR2);
    alu_result = aluFull[7:0];
    alu_ovf    = (aluIdx == 3'd6) && aluFull[8];
  end

  // Transaction-level model: timestamps for readiness, response and ALU load
  bit         mParked = 1'b1;
  bit         mBusy = 1'b0;
  bit         mExpErr = 1'b0;
  int         mReadyFrom = 0;
  int         mRspFrom = 0;
  int         mLoadAt = -1000;
  int         mErrAt = -1000;
  logic [7:0] mLastGood = 8'd0;
  logic [7:0] mExpData = 8'd0;
  logic [7:0] mNum1 = 8'd0;
  logic [7:0] mNum2 = 8'd0;
  logic [6:0] mOutSel = 7'd0;
  logic [8:0] mCalc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mParked <= 1'b1; mBusy <= 1'b0; mExpErr <= 1'b0;
      mReadyFrom <= 0; mRspFrom <= 0; mLoadAt <= -1000; mErrAt <= -1000;
      mLastGood <= 8'd0;
    end else if (mParked) begin
      if (on) mParked <= 1'b0;
    end else if (mBusy) begin
      if (cyc >= mRspFrom && rsp_ready) begin
        mBusy <= 1'b0;
        if (mExpErr) begin
          mLastGood <= 8'd0; mReadyFrom <= cyc + 2; mErrAt <= cyc + 1;
        end else begin
          mLastGood <= mExpData; mReadyFrom <= cyc + 1;
        end
      end
    end else if (cyc >= mReadyFrom) begin
      if (!on) mParked <= 1'b1;
      else if (req_valid) begin
        mCalc = refOp(req_op, req_chain ? mLastGood : req_a, req_b);
        mBusy    <= 1'b1;
        mExpData <= mCalc[7:0];
        mExpErr  <= mCalc[8];
        if (req_op == 3'd7) begin
          mRspFrom <= cyc + 1;
        end else begin
          mRspFrom <= cyc + LAT + 1;
          mLoadAt  <= cyc + 1;
          mNum1    <= req_chain ? mLastGood : req_a;
          mNum2    <= (req_op == 3'd2) ? 8'd0 : req_b;
          mOutSel  <= 7'(8'd1 << req_op);
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  bit expReady, expValid;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_state", 32'(state), 32'(alu_pkg::ST_OFF));
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_in_sel", 32'(alu_in_sel), 32'b001);
      chk("rst_num1", 32'(alu_num1), 32'd0);
      chk("rst_num2", 32'(alu_num2), 32'd0);
      chk("rst_out_sel", 32'(alu_out_sel), 32'd0);
    end else begin
      expReady = !mParked && !mBusy && (cyc >= mReadyFrom) && on;
      expValid = mBusy && (cyc >= mRspFrom);
      chk("req_ready", 32'(req_ready), 32'(expReady));
      chk("rsp_valid", 32'(rsp_valid), 32'(expValid));
      if (expValid) begin
        chk("rsp_data", 32'(rsp_data), 32'(mExpData));
        chk("rsp_err", 32'(rsp_err), 32'(mExpErr));
      end
      if (cyc == mLoadAt) begin
        chk("in_sel_load", 32'(alu_in_sel), 32'b010);
        chk("num1", 32'(alu_num1), 32'(mNum1));
        chk("num2", 32'(alu_num2), 32'(mNum2));
        chk("out_sel", 32'(alu_out_sel), 32'(mOutSel));
      end else begin
        chk("in_sel_no_load", 32'(alu_in_sel[1]), 32'd0);
      end
      if (cyc > mLoadAt && cyc < mLoadAt + LAT) chk("in_sel_persist", 32'(alu_in_sel), 32'b100);
      if (mParked || cyc == mErrAt) chk("in_sel_reset", 32'(alu_in_sel), 32'b001);
    end
  end

  task automatic sendReq(input logic [2:0] op, input logic chain, input logic [7:0] a,
                         input logic [7:0] b, output int tAcc, output bit ok);
    ok = 1'b0;
    tAcc = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_chain = chain; req_a = a; req_b = b; rsp_ready = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; tAcc = cyc; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("accepted", 32'(ok), 32'd1);
  endtask

  task automatic doOp(input logic [2:0] op, input logic chain, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] expData, input logic expErr, input int hold);
    int tAcc, tRsp;
    bit ok, seen;
    sendReq(op, chain, a, b, tAcc, ok);
    seen = 1'b0;
    tRsp = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; tRsp = cyc; end
    end
    chk("rsp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(tRsp - tAcc), (op == 3'd7) ? 32'd1 : 32'(LAT + 1));
    chk("lit_data", 32'(rsp_data), 32'(expData));
    chk("lit_err", 32'(rsp_err), 32'(expErr));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(expData));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_rsp", 32'(req_ready), 32'(!expErr));
    if (expErr) chk("err_in_sel", 32'(alu_in_sel), 32'b001);
  endtask

  initial begin
    int tAcc;
    bit ok;
    #2;
    rst_n = 1'b0;
    on = 1'b1; req_valid = 1'b1; req_op = 3'd4; req_a = 8'h55; req_b = 8'h0F; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    on = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("off_hold", 32'(state), 32'(alu_pkg::ST_OFF));
    end
    @(posedge clk); #1;
    on = 1'b1;

    doOp(3'd4, 1'b0, 8'd100, 8'd27, 8'd127, 1'b0, 0);  // ADD
    doOp(3'd6, 1'b1, 8'd0,   8'd2,  8'd254, 1'b0, 0);  // MUL chained
    doOp(3'd6, 1'b1, 8'd0,   8'd2,  8'd252, 1'b1, 0);  // MUL chained, overflow
    doOp(3'd4, 1'b1, 8'd0,   8'd5,  8'd5,   1'b0, 0);  // chain restarts at zero
    doOp(3'd7, 1'b0, 8'hFF,  8'd0,  8'd0,   1'b1, 0);  // illegal opcode
    doOp(3'd3, 1'b0, 8'hF0,  8'h3C, 8'hCC,  1'b0, 5);  // XOR with backpressure
    doOp(3'd2, 1'b0, 8'h0F,  8'hAA, 8'hF0,  1'b0, 0);  // NOT ignores B

    // Reset pulse in the middle of a SUB
    sendReq(3'd5, 1'b0, 8'd9, 8'd4, tAcc, ok);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", 32'(state), 32'(alu_pkg::ST_OFF));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    end
    doOp(3'd4, 1'b1, 8'd77, 8'd3, 8'd3, 1'b0, 0);  // accumulator cleared by reset

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      on        = ($urandom_range(0, 99) < 95);
      req_valid = ($urandom_range(0, 99) < 60);
      req_op    = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      req_chain = 1'($urandom_range(0, 1));
      req_a     = 8'($urandom);
      req_b     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 60);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1; on = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d of %0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
